// File: rtl/rom_read_arbiter.sv
// Two-port round-robin read arbiter in front of a 256-bit combinational ROM.
// Extracts the addressed 32-bit word and returns it through a registered response slot per port.
module rom_read_arbiter #(
    parameter int unsigned LINES = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid_i,
    output logic         req0_ready_o,
    input  logic [31:0]  req0_addr_i,
    input  logic         req1_valid_i,
    output logic         req1_ready_o,
    input  logic [31:0]  req1_addr_i,
    output logic         rsp0_valid_o,
    input  logic         rsp0_ready_i,
    output logic [31:0]  rsp0_data_o,
    output logic         rsp0_err_o,
    output logic         rsp1_valid_o,
    input  logic         rsp1_ready_i,
    output logic [31:0]  rsp1_data_o,
    output logic         rsp1_err_o,
    output logic [31:0]  rom_a_o,
    input  logic [255:0] rom_rd_i
);

    logic        rsp0_valid_q, rsp0_valid_d;
    logic        rsp1_valid_q, rsp1_valid_d;
    logic [31:0] rsp0_data_q, rsp0_data_d;
    logic [31:0] rsp1_data_q, rsp1_data_d;
    logic        rsp0_err_q, rsp0_err_d;
    logic        rsp1_err_q, rsp1_err_d;
    logic        last_q, last_d;

    logic        elig0, elig1;
    logic        grant0, grant1;
    logic [31:0] sel_addr;
    logic [26:0] sel_line;
    logic [2:0]  sel_word;
    logic        sel_err;
    logic [31:0] sel_data;

    // A slot is free when empty or being drained this cycle.
    assign elig0 = req0_valid_i && (!rsp0_valid_q || rsp0_ready_i);
    assign elig1 = req1_valid_i && (!rsp1_valid_q || rsp1_ready_i);

    // Grants are held off while reset is asserted so ready stays low.
    assign grant0 = rst_n && elig0 && (!elig1 || last_q);
    assign grant1 = rst_n && elig1 && (!elig0 || !last_q);

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;

    always_comb begin
        sel_addr = grant1 ? req1_addr_i : req0_addr_i;
        sel_line = sel_addr[31:5];
        sel_word = sel_addr[4:2];
        sel_err  = (sel_addr[1:0] != 2'b00) || ({5'b0, sel_line} >= LINES);
        sel_data = sel_err ? 32'h0 : rom_rd_i[32*sel_word +: 32];
        rom_a_o  = (grant0 || grant1) ? {5'b0, sel_line} : 32'h0;
    end

    always_comb begin
        rsp0_valid_d = rsp0_valid_q;
        rsp0_data_d  = rsp0_data_q;
        rsp0_err_d   = rsp0_err_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp1_data_d  = rsp1_data_q;
        rsp1_err_d   = rsp1_err_q;
        last_d       = last_q;
        if (grant0) begin
            rsp0_valid_d = 1'b1;
            rsp0_data_d  = sel_data;
            rsp0_err_d   = sel_err;
            last_d       = 1'b0;
        end else if (rsp0_ready_i) begin
            rsp0_valid_d = 1'b0;
        end
        if (grant1) begin
            rsp1_valid_d = 1'b1;
            rsp1_data_d  = sel_data;
            rsp1_err_d   = sel_err;
            last_d       = 1'b1;
        end else if (rsp1_ready_i) begin
            rsp1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid_q <= 1'b0;
            rsp0_data_q  <= 32'h0;
            rsp0_err_q   <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp1_data_q  <= 32'h0;
            rsp1_err_q   <= 1'b0;
            last_q       <= 1'b1;
        end else begin
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp0_err_q   <= rsp0_err_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_data_q  <= rsp1_data_d;
            rsp1_err_q   <= rsp1_err_d;
            last_q       <= last_d;
        end
    end

    assign rsp0_valid_o = rsp0_valid_q;
    assign rsp0_data_o  = rsp0_data_q;
    assign rsp0_err_o   = rsp0_err_q;
    assign rsp1_valid_o = rsp1_valid_q;
    assign rsp1_data_o  = rsp1_data_q;
    assign rsp1_err_o   = rsp1_err_q;

endmodule

// File: doc/rom_read_arbiter.md
# rom_read_arbiter

Two-port round-robin read arbiter and word extractor in front of the 256-bit-wide combinational ROM (`rom256_32`, ports `A`/`RD`). It lets two requesters share that single ROM, for example instruction fetch and constant/data read. Each requester issues 32-bit byte-address word reads over a valid/ready handshake. The block selects the 32-bit word out of the 256-bit line and returns it through a registered, back-pressurable response channel.

## Interface
- `LINES`, 32, number of valid ROM lines; line indices at or above this value are out of range.
- `clk` input 1, rising-edge clock.
- `rst_n` input 1, asynchronous, active-low reset.
- `req0_valid` / `req1_valid` input 1, request present.
- `req0_ready` / `req1_ready` output 1, request accepted this cycle when high together with valid.
- `req0_addr` / `req1_addr` input 32, byte address.
- `rsp0_valid` / `rsp1_valid` output 1, response data valid.
- `rsp0_ready` / `rsp1_ready` input 1, consumer takes the response.
- `rsp0_data` / `rsp1_data` output 32, returned word.
- `rsp0_err` / `rsp1_err` output 1, request was misaligned or out of range.
- `rom_a` output 32, drives ROM `A`.
- `rom_rd` input 256, driven from ROM `RD`.

## Operation
- Address split:
  - line = `addr[31:5]`, zero-extended onto `rom_a`.
  - word = `addr[4:2]`; the returned word is `rom_rd[32*word +: 32]`.
  - `addr[1:0]` must be 0.
- Slot i is free when `!rspi_valid || rspi_ready`. Back-to-back issue with a single response register per port is allowed.
- Eligible i = `reqi_valid && slot i free`.
- Grant:
  - If only one port is eligible, grant it.
  - If both are eligible, grant the port other than `last` (1-bit pointer).
  - At most one grant per cycle.
- `reqi_ready` = grant i. It may depend combinationally on `reqi_valid` and the other port's valid. Requesters must not make valid depend on ready.
- On grant i:
  - `rom_a` = line of `reqi_addr`, same cycle.
  - On the clock edge: `rspi_valid` <= 1, `rspi_data` <= selected word, `rspi_err` <= 0, and `last` <= i.
- Error case, when `addr[1:0] != 0` or line >= `LINES`:
  - The request is still accepted and `last` still updates.
  - `rspi_data` <= 0 and `rspi_err` <= 1.
  - `rom_a` is still driven but its data is discarded.
- With no grant, `rom_a` = 0.
- Response registers:
  - `rspi_valid` clears on `rspi_valid && rspi_ready` unless a new grant to i occurs in the same cycle; in that case the new data loads and valid stays 1.
  - While `rspi_valid && !rspi_ready`, data and err hold stable.
- A stalled response on one port never blocks the other port. Only that port loses eligibility.

## Timing
- Reset values: `rsp0_valid` = `rsp1_valid` = 0, `rsp*_data` = 0, `rsp*_err` = 0, `last` = 1 (port 0 wins the first tie).
- `req*_ready` and `rom_a` are combinational, so they are 0 during reset.
- Latency: a request accepted in cycle N gives a response valid in cycle N+1.
- Throughput: 1 request per cycle total; 1 per 2 cycles per port under continuous contention.
- A `rst_n` assertion mid-operation asynchronously clears all response state and `last`. Pending responses are dropped and are not replayed after reset.
- `rom_rd` is sampled in the grant cycle only. The ROM is combinational with zero latency.

## Test plan
The bench ROM model holds word w of line k = `0x1000_0000 + 8*k + w`. `LINES` = 32.
- Single read: port 0 addr `0x0000_0024` (line 1, word 1), `rsp0_ready` = 1.
  - `req0_ready` high in cycle N.
  - Cycle N+1: `rsp0_valid` = 1, data `0x1000_0009`, err 0.
- Tie and alternation: both ports valid every cycle, port 0 addr `0x40`, port 1 addr `0x5C`, both response readies high.
  - Grants go 0,1,0,1.
  - Port 0 returns `0x1000_0010`; port 1 returns `0x1000_0017`.
- Backpressure: `rsp1_ready` = 0 for 3 cycles with port 1 valid and port 0 valid.
  - `rsp1_data` holds stable and `req1_ready` stays 0.
  - Port 0 is granted every cycle.
  - Once `rsp1_ready` rises, a new port-1 grant occurs in the same cycle.
- Errors:
  - Port 0 addr `0x0000_0002` gives err 1 and data 0.
  - Port 1 addr `0x0000_0400` (line 32) gives err 1 and data 0.
  - The pointer still alternates.
- Reset mid-flight: assert `rst_n` = 0 while `rsp0_valid` = 1.
  - `rsp0_valid`/data/err go to 0 immediately, before the next clock edge.
  - After release, a tie grants port 0 first.
